id_pipe_stage: RTL and testbench
================================

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 4, register address width (4 = RV32E, 5 = RV32I).
REQ-003 SHALL have parameter CTRL_W, default 16, control-signal bundle width.
REQ-004 SHALL have parameter BYPASS_EN, default 1, enables EX/MEM and WB forwarding.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have these upstream ports: in_valid in 1; in_ready out 1; in_instr in 32; in_pc in XLEN.
REQ-007 SHALL have these register-file ports: rs1_addr out REG_AW; rs2_addr out REG_AW; rs1_data in XLEN; rs2_data in XLEN.
REQ-008 SHALL have these forwarding ports: mem_reg_write in 1; mem_rd in REG_AW; mem_data in XLEN; wb_reg_write in 1; wb_rd in REG_AW; wb_data in XLEN.
REQ-009 SHALL have these hazard and flush ports: ex_mem_read in 1 (load in EX); ex_rd in REG_AW; flush in 1.
REQ-010 SHALL have these downstream ports: out_valid out 1; out_ready in 1; out_pc XLEN; out_ctrl CTRL_W; out_imm XLEN; out_rd REG_AW; out_rs1_addr REG_AW; out_rs2_addr REG_AW; out_rs1_data XLEN; out_rs2_data XLEN; out_illegal 1.
REQ-011 SHALL have the statistics port stall_count out 32 (load-use stall cycles).

Function
REQ-012 SHALL decode fields at standard RISC-V positions: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7], each truncated to REG_AW bits.
REQ-013 SHALL, when REG_AW=4 and any of instr[19], instr[24] or instr[11] is set, latch out_illegal=1 with the instruction.
REQ-014 SHALL drive rs1_addr and rs2_addr combinationally from in_instr.
REQ-015 SHALL select forwarded operands with priority MEM > WB > regfile, per operand: match when reg_write=1, rd equals the source, and the source is not 0; a source of x0 always yields 0.
REQ-016 SHALL, when BYPASS_EN=0, take operands from the regfile only, except that x0 still yields 0.
REQ-017 SHALL define hazard = in_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 | ex_rd==rs2), evaluated on the truncated addresses.
REQ-018 SHALL compute in_ready = !flush & !hazard & (!out_valid | out_ready).
REQ-019 SHALL treat a transfer as in_valid & in_ready; on a transfer the output register loads all decoded fields and out_valid=1 on the next edge.
REQ-020 SHALL, when hazard=1 and (!out_valid | out_ready), load a bubble: out_valid=0, other outputs unchanged.
REQ-021 SHALL, when out_valid & !out_ready, hold every output stable, including forwarded data.
REQ-022 SHALL, when flush=1, clear out_valid on the next edge, drop the input in that cycle, and give flush priority over transfer, hazard and hold.
REQ-023 SHALL have a latency of one cycle from accepted input to out_valid.
REQ-024 SHALL increment stall_count on each cycle with hazard=1 and flush=0, saturating at 0xFFFF_FFFF.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set out_valid=0, out_illegal=0, and all out_* data and stall_count to 0.
REQ-026 SHALL hold in_ready=0 while rst=1.
REQ-027 SHALL let reset mid-stall or mid-hold discard the held instruction, with no output on the first cycle after reset.

Structure
REQ-028 SHALL keep opcode constants, CTRL_W and the ctrl-bit layout in the shared core constants file; the module SHALL contain no local opcode literals.
REQ-029 SHALL reuse the existing control and immediate decoders unchanged.
REQ-030 SHALL place the two-level forwarding mux in one natural sub-module, id_fwd_mux, instantiated once per operand.

Verification
REQ-031 SHALL cover reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, stall_count=0.
REQ-032 SHALL cover forwarding priority: add x3,x1,x2 with mem_rd=1 mem_data=0xAAAA_0001 and wb_rd=1 wb_data=0x5555_0002 -> out_rs1_data=0xAAAA_0001; with rs1=x0 -> 0.
REQ-033 SHALL cover load-use: ex_mem_read=1 ex_rd=5 with input using rs2=x5 -> in_ready=0, one bubble, stall_count=1, then the instruction issues when ex_mem_read drops.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles -> outputs unchanged and in_ready=0, then one transfer per cycle resumes.
REQ-035 SHALL cover flush during hold: out_valid=1, out_ready=0, flush=1 -> out_valid=0 next cycle and the input is not accepted.
REQ-036 SHALL cover RV32E illegal access: REG_AW=4 with instr rd=x17 -> out_illegal=1; with REG_AW=5 -> out_illegal=0 and out_rd=17.

Source files
------------

// File: rtl/id_pipe_stage_pkg.sv
// Shared core constants for the decode stage.
// Contents:
//   - RV32 base opcode constants
//   - CTRL_WIDTH and the bit layout of the control bundle
//   - ctrl_decode(): instruction -> control bundle
//   - imm_decode():  instruction -> sign-extended 32-bit immediate
package id_pipe_stage_pkg;

    // Default width of the control bundle carried down the pipe.
    localparam int unsigned CTRL_WIDTH = 16;

    // RV32 major opcodes (instr[6:0]).
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Control bundle bit layout.
    localparam int unsigned CTRL_REG_WRITE   = 0;
    localparam int unsigned CTRL_MEM_READ    = 1;
    localparam int unsigned CTRL_MEM_WRITE   = 2;
    localparam int unsigned CTRL_BRANCH      = 3;
    localparam int unsigned CTRL_JUMP        = 4;
    localparam int unsigned CTRL_ALU_SRC_IMM = 5;
    localparam int unsigned CTRL_ALU_SRC_PC  = 6;
    localparam int unsigned CTRL_USE_RS1     = 7;
    localparam int unsigned CTRL_USE_RS2     = 8;
    localparam int unsigned CTRL_FUNCT3_LSB  = 9;   // 3 bits: [11:9]
    localparam int unsigned CTRL_ALT_OP      = 12;  // SUB / SRA select
    localparam int unsigned CTRL_ILLEGAL_OP  = 13;
    localparam int unsigned CTRL_SYSTEM      = 14;
    localparam int unsigned CTRL_FENCE       = 15;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_sel_e;

    function automatic logic [CTRL_WIDTH-1:0] ctrl_decode(input logic [31:0] instr);
        logic [CTRL_WIDTH-1:0] c;
        c = '0;
        c[CTRL_FUNCT3_LSB +: 3] = instr[14:12];
        case (instr[6:0])
            OPC_LUI: begin
                c[CTRL_REG_WRITE]   = 1'b1;
                c[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_AUIPC: begin
                c[CTRL_REG_WRITE]   = 1'b1;
                c[CTRL_ALU_SRC_IMM] = 1'b1;
                c[CTRL_ALU_SRC_PC]  = 1'b1;
            end
            OPC_JAL: begin
                c[CTRL_REG_WRITE]  = 1'b1;
                c[CTRL_JUMP]       = 1'b1;
                c[CTRL_ALU_SRC_PC] = 1'b1;
            end
            OPC_JALR: begin
                c[CTRL_REG_WRITE]   = 1'b1;
                c[CTRL_JUMP]        = 1'b1;
                c[CTRL_USE_RS1]     = 1'b1;
                c[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_BRANCH: begin
                c[CTRL_BRANCH]  = 1'b1;
                c[CTRL_USE_RS1] = 1'b1;
                c[CTRL_USE_RS2] = 1'b1;
            end
            OPC_LOAD: begin
                c[CTRL_REG_WRITE]   = 1'b1;
                c[CTRL_MEM_READ]    = 1'b1;
                c[CTRL_USE_RS1]     = 1'b1;
                c[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_STORE: begin
                c[CTRL_MEM_WRITE]   = 1'b1;
                c[CTRL_USE_RS1]     = 1'b1;
                c[CTRL_USE_RS2]     = 1'b1;
                c[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_OP_IMM: begin
                c[CTRL_REG_WRITE]   = 1'b1;
                c[CTRL_USE_RS1]     = 1'b1;
                c[CTRL_ALU_SRC_IMM] = 1'b1;
                // Only the shift-right-immediate uses instr[30] as a mode bit.
                c[CTRL_ALT_OP]      = (instr[14:12] == 3'b101) && instr[30];
            end
            OPC_OP: begin
                c[CTRL_REG_WRITE] = 1'b1;
                c[CTRL_USE_RS1]   = 1'b1;
                c[CTRL_USE_RS2]   = 1'b1;
                c[CTRL_ALT_OP]    = instr[30];
            end
            OPC_MISC_MEM: c[CTRL_FENCE]      = 1'b1;
            OPC_SYSTEM:   c[CTRL_SYSTEM]     = 1'b1;
            default:      c[CTRL_ILLEGAL_OP] = 1'b1;
        endcase
        return c;
    endfunction

    function automatic imm_sel_e imm_sel(input logic [6:0] opcode);
        imm_sel_e s;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: s = ImmI;
            OPC_STORE:                      s = ImmS;
            OPC_BRANCH:                     s = ImmB;
            OPC_LUI, OPC_AUIPC:             s = ImmU;
            OPC_JAL:                        s = ImmJ;
            default:                        s = ImmNone;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] imm_decode(input logic [31:0] instr);
        logic [31:0] imm;
        case (imm_sel(instr[6:0]))
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU:    imm = {instr[31:12], 12'b0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Two-level operand forwarding mux for one source operand.
// Priority: x0 -> 0, then EX/MEM result, then WB result, then register file.
// Ports:
//   i_src                                   source register address
//   i_rf_data                               register-file read data
//   i_mem_reg_write / i_mem_rd / i_mem_data EX/MEM write-back candidate
//   i_wb_reg_write  / i_wb_rd  / i_wb_data  WB write-back candidate
//   o_data                                  selected operand
module id_fwd_mux
    import id_pipe_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 4,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_wb_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_data
);

    logic w_src_zero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_zero = (i_src == '0);
    assign w_mem_hit  = BYPASS_EN && i_mem_reg_write && (i_mem_rd == i_src) && !w_src_zero;
    assign w_wb_hit   = BYPASS_EN && i_wb_reg_write && (i_wb_rd == i_src) && !w_src_zero;

    always_comb begin
        o_data = i_rf_data;
        if (w_src_zero) begin
            o_data = '0;
        end else if (w_mem_hit) begin
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage with operand forwarding, load-use
// interlock, flush and valid/ready handshakes on both sides.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc   upstream handshake and payload
//   rs1_addr/rs2_addr/rs1_data/rs2_data   register-file read ports
//   mem_*/wb_*                   forwarding sources (EX/MEM, WB)
//   ex_mem_read/ex_rd            load in EX, for load-use detection
//   flush                        kill the stage contents and the current input
//   out_*                        downstream handshake and decoded payload
//   stall_count                  saturating count of load-use stall cycles
module id_pipe_stage
    import id_pipe_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned CTRL_W    = CTRL_WIDTH,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1_addr,
    output logic [REG_AW-1:0] out_rs2_addr,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic              out_illegal,
    output logic [31:0]       stall_count
);

    // Decode
    logic [REG_AW-1:0]     w_rs1;
    logic [REG_AW-1:0]     w_rs2;
    logic [REG_AW-1:0]     w_rd;
    logic                  w_illegal_reg;
    logic [CTRL_WIDTH-1:0] w_ctrl_dec;
    logic [CTRL_W-1:0]     w_ctrl;
    logic [XLEN-1:0]       w_imm;
    logic [XLEN-1:0]       w_rs1_fwd;
    logic [XLEN-1:0]       w_rs2_fwd;

    assign w_rs1 = in_instr[15 +: REG_AW];
    assign w_rs2 = in_instr[20 +: REG_AW];
    assign w_rd  = in_instr[7 +: REG_AW];

    // RV32E has only x0..x15; the top address bit of any field must be clear.
    assign w_illegal_reg = (REG_AW == 4) && (in_instr[19] || in_instr[24] || in_instr[11]);

    assign w_ctrl_dec = ctrl_decode(in_instr);
    assign w_ctrl     = CTRL_W'(w_ctrl_dec);
    assign w_imm      = XLEN'($signed(imm_decode(in_instr)));

    assign rs1_addr = w_rs1;
    assign rs2_addr = w_rs2;

    id_fwd_mux #(
        .XLEN      (XLEN),
        .REG_AW    (REG_AW),
        .BYPASS_EN (BYPASS_EN)
    ) u_fwd_rs1 (
        .i_src           (w_rs1),
        .i_rf_data       (rs1_data),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_mem_data      (mem_data),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_data       (wb_data),
        .o_data          (w_rs1_fwd)
    );

    id_fwd_mux #(
        .XLEN      (XLEN),
        .REG_AW    (REG_AW),
        .BYPASS_EN (BYPASS_EN)
    ) u_fwd_rs2 (
        .i_src           (w_rs2),
        .i_rf_data       (rs2_data),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_mem_data      (mem_data),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_data       (wb_data),
        .o_data          (w_rs2_fwd)
    );

    // Handshake / hazard
    logic w_hazard;
    logic w_out_free;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [CTRL_W-1:0] r_ctrl;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic              r_illegal;
    logic [31:0]       r_stall_count;

    // Load in EX whose result one of our sources needs: it is not forwardable yet.
    assign w_hazard   = in_valid && ex_mem_read && (ex_rd != '0) &&
                        ((ex_rd == w_rs1) || (ex_rd == w_rs2));
    assign w_out_free = !r_valid || out_ready;
    assign in_ready   = !rst && !flush && !w_hazard && w_out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_ctrl     <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!w_out_free) begin
            // Downstream stalled: hold everything, forwarded data included.
            r_valid <= r_valid;
        end else if (w_hazard || !in_valid) begin
            // Bubble: payload fields left as they were.
            r_valid <= 1'b0;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= in_pc;
            r_ctrl     <= w_ctrl;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_rs1_addr <= w_rs1;
            r_rs2_addr <= w_rs2;
            r_rs1_data <= w_rs1_fwd;
            r_rs2_data <= w_rs2_fwd;
            r_illegal  <= w_illegal_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_hazard && !flush && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_ctrl     = r_ctrl;
    assign out_imm      = r_imm;
    assign out_rd       = r_rd;
    assign out_rs1_addr = r_rs1_addr;
    assign out_rs2_addr = r_rs2_addr;
    assign out_rs1_data = r_rs1_data;
    assign out_rs2_data = r_rs2_data;
    assign out_illegal  = r_illegal;
    assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: one RV32E (REG_AW=4) and one RV32I
// (REG_AW=5) instance driven by the same stimulus.
module tb_id_pipe_stage;

    // add x3,x1,x2 / add x3,x0,x2 / add x6,x1,x5 / addi x17,x0,5
    localparam logic [31:0] I_ADD     = 32'h0020_81B3;
    localparam logic [31:0] I_ADD_X0  = 32'h0020_01B3;
    localparam logic [31:0] I_LDUSE   = 32'h0050_8333;
    localparam logic [31:0] I_ADDI17  = 32'h0050_0893;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [15:0] out_ctrl;
    logic [31:0] out_imm;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs1_addr;
    logic [3:0]  out_rs2_addr;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic        out_illegal;
    logic [31:0] stall_count;

    logic        d5_in_ready;
    logic [4:0]  d5_rs1_addr;
    logic [4:0]  d5_rs2_addr;
    logic        d5_out_valid;
    logic [31:0] d5_out_pc;
    logic [15:0] d5_out_ctrl;
    logic [31:0] d5_out_imm;
    logic [4:0]  d5_out_rd;
    logic [4:0]  d5_out_rs1_addr;
    logic [4:0]  d5_out_rs2_addr;
    logic [31:0] d5_out_rs1_data;
    logic [31:0] d5_out_rs2_data;
    logic        d5_out_illegal;
    logic [31:0] d5_stall_count;

    int errors = 0;
    int checks = 0;

    id_pipe_stage #(
        .XLEN      (32),
        .REG_AW    (4),
        .CTRL_W    (16),
        .BYPASS_EN (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd[3:0]),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd[3:0]),
        .wb_data       (wb_data),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd[3:0]),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_ctrl      (out_ctrl),
        .out_imm       (out_imm),
        .out_rd        (out_rd),
        .out_rs1_addr  (out_rs1_addr),
        .out_rs2_addr  (out_rs2_addr),
        .out_rs1_data  (out_rs1_data),
        .out_rs2_data  (out_rs2_data),
        .out_illegal   (out_illegal),
        .stall_count   (stall_count)
    );

    id_pipe_stage #(
        .XLEN      (32),
        .REG_AW    (5),
        .CTRL_W    (16),
        .BYPASS_EN (1'b1)
    ) dut5 (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (d5_in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs1_addr      (d5_rs1_addr),
        .rs2_addr      (d5_rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .flush         (flush),
        .out_valid     (d5_out_valid),
        .out_ready     (out_ready),
        .out_pc        (d5_out_pc),
        .out_ctrl      (d5_out_ctrl),
        .out_imm       (d5_out_imm),
        .out_rd        (d5_out_rd),
        .out_rs1_addr  (d5_out_rs1_addr),
        .out_rs2_addr  (d5_out_rs2_addr),
        .out_rs1_data  (d5_out_rs1_data),
        .out_rs2_data  (d5_out_rs2_data),
        .out_illegal   (d5_out_illegal),
        .stall_count   (d5_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b1;
        in_instr      = I_ADD;
        in_pc         = 32'h100;
        rs1_data      = 32'h1111_1111;
        rs2_data      = 32'h2222_2222;
        mem_reg_write = 1'b0;
        mem_rd        = 5'd0;
        mem_data      = 32'h0;
        wb_reg_write  = 1'b0;
        wb_rd         = 5'd0;
        wb_data       = 32'h0;
        ex_mem_read   = 1'b0;
        ex_rd         = 5'd0;
        flush         = 1'b0;
        out_ready     = 1'b1;

        // Reset for two cycles with in_valid held high
        #1;
        check("rst_in_ready_comb", in_ready, 0);
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_rs1_data", out_rs1_data, 0);

        // Forwarding priority: MEM beats WB for rs1=x1
        rst           = 1'b0;
        mem_reg_write = 1'b1;
        mem_rd        = 5'd1;
        mem_data      = 32'hAAAA_0001;
        wb_reg_write  = 1'b1;
        wb_rd         = 5'd1;
        wb_data       = 32'h5555_0002;
        #1;
        check("rs1_addr_comb", rs1_addr, 1);
        check("rs2_addr_comb", rs2_addr, 2);
        check("fwd_in_ready", in_ready, 1);
        step();
        check("fwd_out_valid", out_valid, 1);
        check("fwd_mem_rs1", out_rs1_data, 32'hAAAA_0001);
        check("fwd_rf_rs2", out_rs2_data, 32'h2222_2222);
        check("fwd_out_rd", out_rd, 3);
        check("fwd_out_ctrl", out_ctrl, 16'h0181);
        check("fwd_out_pc", out_pc, 32'h100);

        // WB only
        mem_reg_write = 1'b0;
        in_pc         = 32'h104;
        step();
        check("fwd_wb_rs1", out_rs1_data, 32'h5555_0002);
        check("fwd_wb_pc", out_pc, 32'h104);

        // rs1 = x0 always reads 0, even with writers targeting x0
        in_instr      = I_ADD_X0;
        mem_reg_write = 1'b1;
        mem_rd        = 5'd0;
        wb_rd         = 5'd0;
        in_pc         = 32'h108;
        step();
        check("fwd_x0_rs1", out_rs1_data, 0);
        check("fwd_x0_rs1_addr", out_rs1_addr, 0);

        // Load-use on rs2 = x5: one bubble, then issue
        mem_reg_write = 1'b0;
        wb_reg_write  = 1'b0;
        in_instr      = I_LDUSE;
        in_pc         = 32'h10C;
        ex_mem_read   = 1'b1;
        ex_rd         = 5'd5;
        #1;
        check("lu_in_ready", in_ready, 0);
        step();
        check("lu_bubble_valid", out_valid, 0);
        check("lu_stall_count", stall_count, 1);
        check("lu_bubble_pc_kept", out_pc, 32'h108);
        ex_mem_read = 1'b0;
        #1;
        check("lu_in_ready_after", in_ready, 1);
        step();
        check("lu_issue_valid", out_valid, 1);
        check("lu_issue_rd", out_rd, 6);
        check("lu_issue_rs2", out_rs2_data, 32'h2222_2222);
        check("lu_issue_pc", out_pc, 32'h10C);
        check("lu_stall_kept", stall_count, 1);

        // Backpressure for three cycles; upstream data changes meanwhile
        out_ready = 1'b0;
        in_instr  = I_ADD;
        in_pc     = 32'h110;
        rs2_data  = 32'h4444_4444;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            step();
            check("bp_valid", out_valid, 1);
            check("bp_rd", out_rd, 6);
            check("bp_rs2_held", out_rs2_data, 32'h2222_2222);
            check("bp_pc", out_pc, 32'h10C);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_rd", out_rd, 3);
        check("bp_next_rs2", out_rs2_data, 32'h4444_4444);
        check("bp_next_pc", out_pc, 32'h110);

        // Back-to-back transfer: rd = x17 is illegal only on RV32E
        in_instr = I_ADDI17;
        in_pc    = 32'h114;
        step();
        check("ill_valid", out_valid, 1);
        check("ill_rv32e", out_illegal, 1);
        check("ill_rv32e_rd", out_rd, 1);
        check("ill_imm", out_imm, 5);
        check("ill_ctrl", out_ctrl, 16'h00A1);
        check("ill_rv32i_valid", d5_out_valid, 1);
        check("ill_rv32i", d5_out_illegal, 0);
        check("ill_rv32i_rd", d5_out_rd, 17);

        // Flush during hold, with a coincident load-use hazard
        out_ready   = 1'b0;
        flush       = 1'b1;
        in_instr    = I_ADD;
        in_pc       = 32'h118;
        ex_mem_read = 1'b1;
        ex_rd       = 5'd1;
        #1;
        check("fl_in_ready", in_ready, 0);
        step();
        check("fl_valid", out_valid, 0);
        check("fl_not_accepted_rd", out_rd, 1);
        check("fl_not_accepted_pc", out_pc, 32'h114);
        check("fl_no_stall_count", stall_count, 1);

        // Reset in the middle of a hold + stall
        flush       = 1'b0;
        ex_mem_read = 1'b0;
        out_ready   = 1'b1;
        in_pc       = 32'h11C;
        step();
        check("rh_loaded", out_valid, 1);
        out_ready   = 1'b0;
        ex_mem_read = 1'b1;
        ex_rd       = 5'd2;
        step();
        check("rh_hold_valid", out_valid, 1);
        check("rh_stall_count", stall_count, 2);
        rst = 1'b1;
        step();
        check("rh_rst_valid", out_valid, 0);
        check("rh_rst_stall", stall_count, 0);
        check("rh_rst_rd", out_rd, 0);
        rst         = 1'b0;
        ex_mem_read = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        step();
        check("rh_after_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
